audio_adc: RTL and testbench

Stereo sigma-delta / PDM capture block: the receive-side counterpart of the audio DAC path. Two 1-bit modulator bitstreams (left, right) are sampled on bit-clock strobes, decimated by a second-order CIC filter, scaled to signed 16-bit and presented as packed stereo words on an AXI-Stream master port. It sits between external PDM microphones or ADC modulators and the audio DMA/FIFO fabric.

---
 rtl/audio_adc.sv | 142 ++++++++++++++
 tb/tb_audio_adc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc.sv
// audio_adc: stereo PDM / sigma-delta capture. Second-order CIC decimator
//   (R = 2**DECIM_LOG2) per channel, scaling to saturated signed 16-bit,
//   packed {right, left} stereo words on an AXI-Stream master.
// Latency: dump strobe in cycle N -> comb/scale in N+1 -> tvalid in N+2.
// Backpressure: single holding word; a frame arriving while the held word is
//   unaccepted pulses overrun_o and is dropped, or replaces the held word
//   when AUDIO_ADC_OVERWRITE_EN is defined.
// Ports: clk_i/rst_i (async, active-high); audio_clk_i bit strobe;
//   audio_l_i/audio_r_i bitstreams; outport_* AXI-Stream master
//   (tstrb/tdest/tlast constant); overrun_o collision pulse.
module audio_adc #(
  parameter int DECIM_LOG2 = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        audio_clk_i,
  input  logic        audio_l_i,
  input  logic        audio_r_i,
  output logic        outport_tvalid_o,
  output logic [31:0] outport_tdata_o,
  output logic [3:0]  outport_tstrb_o,
  output logic [3:0]  outport_tdest_o,
  output logic        outport_tlast_o,
  input  logic        outport_tready_i,
  output logic        overrun_o
);

  localparam int W     = 2*DECIM_LOG2 + 2;
  localparam int SHIFT = 15 - 2*DECIM_LOG2;

  // Index 0 = left, 1 = right.
  logic [1:0][W-1:0]      i1_q, i1_d, i2_q, i2_d;
  logic [1:0][W-1:0]      i2dly_q, i2dly_d, c1dly_q, c1dly_d;
  logic [1:0][W-1:0]      c1_w, c2_w;
  logic [1:0][17:0]       scl_w;
  logic [1:0][15:0]       smp_w;
  logic [1:0]             bits_w;
  logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
  logic                   dump_q, dump_d;
  logic [1:0]             flush_q, flush_d;
  logic                   tvalid_q, tvalid_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   overrun_q, overrun_d;
  logic                   load_w, collide_w;

  assign bits_w = {audio_r_i, audio_l_i};

  // Integrators: free-running modular arithmetic; the comb stage cancels wrap.
  always_comb begin
    i1_d = i1_q;
    i2_d = i2_q;
    if (audio_clk_i) begin
      for (int ch = 0; ch < 2; ch++) begin
        i1_d[ch] = bits_w[ch] ? (i1_q[ch] + W'(1)) : (i1_q[ch] - W'(1));
        i2_d[ch] = i2_q[ch] + i1_q[ch];
      end
    end
  end

  // Comb and scale, evaluated every cycle but only consumed when dump_q is set.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      c1_w[ch]  = i2_q[ch] - i2dly_q[ch];
      c2_w[ch]  = c1_w[ch] - c1dly_q[ch];
      scl_w[ch] = {{(18-W){c2_w[ch][W-1]}}, c2_w[ch]} << SHIFT;
      // Fits in 16 bits only if the top three bits agree.
      if (!scl_w[ch][17] && (scl_w[ch][16:15] != 2'b00)) begin
        smp_w[ch] = 16'h7FFF;
      end else if (scl_w[ch][17] && (scl_w[ch][16:15] != 2'b11)) begin
        smp_w[ch] = 16'h8000;
      end else begin
        smp_w[ch] = scl_w[ch][15:0];
      end
    end
  end

  // Decimation timing and comb delay lines.
  always_comb begin
    cnt_d   = audio_clk_i ? (cnt_q + DECIM_LOG2'(1)) : cnt_q;
    dump_d  = audio_clk_i && (cnt_q == '1);
    flush_d = (dump_q && (flush_q != 2'd2)) ? (flush_q + 2'd1) : flush_q;
    i2dly_d = dump_q ? i2_q : i2dly_q;
    c1dly_d = dump_q ? c1_w : c1dly_q;
  end

  // The first two frames after reset carry start-up transients and are dropped.
  assign load_w    = dump_q && (flush_q == 2'd2);
  assign collide_w = load_w && tvalid_q && !outport_tready_i;

  // Output holding register.
  always_comb begin
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    overrun_d = collide_w;
    if (load_w) begin
      tvalid_d = 1'b1;
`ifdef AUDIO_ADC_OVERWRITE_EN
      tdata_d = smp_w;
`else
      if (!collide_w) begin
        tdata_d = smp_w;
      end
`endif
    end else if (tvalid_q && outport_tready_i) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i1_q      <= '0;
      i2_q      <= '0;
      i2dly_q   <= '0;
      c1dly_q   <= '0;
      cnt_q     <= '0;
      dump_q    <= 1'b0;
      flush_q   <= 2'd0;
      tvalid_q  <= 1'b0;
      tdata_q   <= 32'd0;
      overrun_q <= 1'b0;
    end else begin
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i2dly_q   <= i2dly_d;
      c1dly_q   <= c1dly_d;
      cnt_q     <= cnt_d;
      dump_q    <= dump_d;
      flush_q   <= flush_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      overrun_q <= overrun_d;
    end
  end

  assign outport_tvalid_o = tvalid_q;
  assign outport_tdata_o  = tdata_q;
  assign outport_tstrb_o  = 4'hF;
  assign outport_tdest_o  = 4'h0;
  assign outport_tlast_o  = 1'b1;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_audio_adc.sv
// tb_audio_adc: randomized and directed stimulus for audio_adc (R = 16),
//   compared cycle by cycle against a triangular-window CIC reference model.
module tb_audio_adc;

  localparam int DL = 4;
  localparam int R  = 1 << DL;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        audio_clk_i = 1'b0;
  logic        audio_l_i = 1'b0;
  logic        audio_r_i = 1'b0;
  logic        outport_tready_i = 1'b0;
  logic        outport_tvalid_o;
  logic [31:0] outport_tdata_o;
  logic [3:0]  outport_tstrb_o;
  logic [3:0]  outport_tdest_o;
  logic        outport_tlast_o;
  logic        overrun_o;

  audio_adc #(.DECIM_LOG2(DL)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .audio_clk_i      (audio_clk_i),
    .audio_l_i        (audio_l_i),
    .audio_r_i        (audio_r_i),
    .outport_tvalid_o (outport_tvalid_o),
    .outport_tdata_o  (outport_tdata_o),
    .outport_tstrb_o  (outport_tstrb_o),
    .outport_tdest_o  (outport_tdest_o),
    .outport_tlast_o  (outport_tlast_o),
    .outport_tready_i (outport_tready_i),
    .overrun_o        (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int          ql[$];
  int          qr[$];
  int          strobes;
  int          frames;
  int          cyc;
  bit          pend;
  logic [31:0] pend_word;
  bit          m_vld;
  logic [31:0] m_dat;
  bit          m_ovr;

  // Second-order CIC output as a direct triangular-weighted sum of the last
  // 2R input samples (age 0 = newest): weight m for m < R, 2R - m otherwise.
  function automatic int cic_out(input int q[$]);
    int acc = 0;
    int n = q.size();
    for (int m = 0; m < 2*R; m++)
      if (m < n) acc += q[n-1-m] * ((m < R) ? m : (2*R - m));
    return acc;
  endfunction

  function automatic logic [15:0] scale(input int c2);
    longint v = longint'(c2) * (longint'(1) << (15 - 2*DL));
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic model_reset();
    ql.delete();
    qr.delete();
    strobes = 0;
    frames  = 0;
    pend    = 0;
    pend_word = 32'd0;
    m_vld = 0;
    m_dat = 32'd0;
    m_ovr = 0;
  endtask

  // Asynchronous reset pulse starting at posedge+1; outputs checked before
  // any clock edge; returns at posedge+1 with reset released.
  task automatic do_reset();
    rst_i = 1'b1;
    audio_clk_i = 1'b0;
    #2;
    check_eq("rst_tvalid", 32'(outport_tvalid_o), 32'd0);
    check_eq("rst_tdata", outport_tdata_o, 32'd0);
    check_eq("rst_overrun", 32'(overrun_o), 32'd0);
    check_eq("rst_const", 32'({outport_tstrb_o, outport_tdest_o, outport_tlast_o}), 32'h1E1);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // bmode: 0 both 1, 1 left 1/right 0, 2 alternating, 3 random.
  // period: strobe every period cycles, 0 = random strobes.
  // rmode: 0 ready, 1 stalled, 2 random, 3 ready only in load cycles.
  task automatic run(input int bmode, input int period, input int rmode, input int ncyc);
    bit stb, bl, br, rdy, load, nv, no;
    logic [31:0] lw, nd;
    for (int k = 0; k < ncyc; k++) begin
      stb = (period == 0) ? bit'($urandom_range(0, 1)) : ((cyc % period) == 0);
      case (bmode)
        0: begin bl = 1; br = 1; end
        1: begin bl = 1; br = 0; end
        2: begin bl = bit'(strobes % 2); br = bl; end
        default: begin bl = bit'($urandom_range(0, 1)); br = bit'($urandom_range(0, 1)); end
      endcase
      case (rmode)
        0: rdy = 1;
        1: rdy = 0;
        2: rdy = bit'($urandom_range(0, 1));
        default: rdy = pend;
      endcase
      audio_clk_i = stb;
      audio_l_i = bl;
      audio_r_i = br;
      outport_tready_i = rdy;

      @(negedge clk_i);
      check_eq("tvalid", 32'(outport_tvalid_o), 32'(m_vld));
      check_eq("tdata", outport_tdata_o, m_dat);
      check_eq("overrun", 32'(overrun_o), 32'(m_ovr));
      check_eq("const", 32'({outport_tstrb_o, outport_tdest_o, outport_tlast_o}), 32'h1E1);

      // Frame completed last cycle is presented at the end of this cycle.
      load = pend;
      lw = pend_word;
      pend = 0;
      if (stb) begin
        ql.push_back(bl ? 1 : -1);
        qr.push_back(br ? 1 : -1);
        if (ql.size() > 2*R) void'(ql.pop_front());
        if (qr.size() > 2*R) void'(qr.pop_front());
        strobes++;
        if (strobes % R == 0) begin
          frames++;
          if (frames > 2) begin
            pend = 1;
            pend_word = {scale(cic_out(qr)), scale(cic_out(ql))};
          end
        end
      end
      nv = m_vld;
      nd = m_dat;
      no = 0;
      if (load) begin
        if (m_vld && !rdy) begin
          no = 1;
`ifdef AUDIO_ADC_OVERWRITE_EN
          nd = lw;
`endif
        end else begin
          nd = lw;
        end
        nv = 1;
      end else if (m_vld && rdy) begin
        nv = 0;
      end
      m_vld = nv;
      m_dat = nd;
      m_ovr = no;
      cyc++;

      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    #2;
    do_reset();

    run(0, 1, 0, 6*R);        // saturating full-scale positive
    run(1, 1, 0, 6*R);        // left +FS, right -FS
    run(2, 1, 0, 4*R);        // alternating -> zero
    run(2, 3, 0, 4*3*R);      // slow bit clock
    run(3, 1, 1, 2*R + 6);    // stall across two frames: collision
    run(3, 1, 0, 2*R);
    run(3, 1, 3, 6*R);        // accept in the load cycle
    run(3, 0, 2, 600);        // fully random
    run(3, 1, 1, R + 5);      // hold a word, then reset mid-frame
    do_reset();
    run(0, 1, 0, 5*R);        // flush repeats after reset
    run(3, 2, 2, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
